// File: rtl/queue_obj.sv
// Free-list FIFO for rename: first-word-fall-through head, flush/stall control,
// and a halt flag that rename uses to back-pressure when no register is free.
module queue_obj #(
  parameter int LENGTH = 32,
  parameter int WIDTH  = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           flush,
  input  logic                           enque,
  input  logic [WIDTH-1:0]               enque_data,
  input  logic                           deque,
  output logic [WIDTH-1:0]               deque_data,
  output logic                           halt,
  output logic                           full,
  output logic [$clog2(LENGTH+1)-1:0]    count
);

  localparam int PW = $clog2(LENGTH);
  localparam int CW = $clog2(LENGTH+1);

  logic [WIDTH-1:0] mem [LENGTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             deq_ok;
  logic             enq_ok;

  assign halt       = (count == '0);
  assign full       = (count == CW'(LENGTH));
  assign deque_data = halt ? '0 : mem[head];

  // A pop frees a slot this cycle, so a full queue can still take a write alongside it.
  assign deq_ok = deque && !stall && !halt;
  assign enq_ok = enque && (!full || deq_ok);

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(LENGTH-1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_ok)
        tail <= next_ptr(tail);
      if (deq_ok)
        head <= next_ptr(head);
      case ({enq_ok, deq_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; stale words are masked by the empty check on the output.
  always_ff @(posedge clk) begin
    if (!reset && !flush && enq_ok)
      mem[tail] <= enque_data;
  end

endmodule

// File: tb/tb_queue_obj.sv
// Directed self-checking bench for queue_obj: a vector table for the basic
// sequences plus hand-written full/wrap and asynchronous reset scenarios.
module tb_queue_obj;

  localparam int LENGTH = 32;
  localparam int WIDTH  = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic             flush;
  logic             enque;
  logic [WIDTH-1:0] enque_data;
  logic             deque;
  logic [WIDTH-1:0] deque_data;
  logic             halt;
  logic             full;
  logic [5:0]       count;

  int checks = 0;
  int errors = 0;

  queue_obj #(.LENGTH(LENGTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .enque      (enque),
    .enque_data (enque_data),
    .deque      (deque),
    .deque_data (deque_data),
    .halt       (halt),
    .full       (full),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Each row: inputs applied for one cycle, expected outputs are the state seen before that edge.
  typedef struct {
    logic             stall;
    logic             flush;
    logic             enque;
    logic [WIDTH-1:0] data;
    logic             deque;
    logic [WIDTH-1:0] exp_data;
    logic             exp_halt;
    logic             exp_full;
    logic [5:0]       exp_count;
  } vec_t;

  vec_t vecs [29];

  task automatic check_output(input string name, input logic [WIDTH-1:0] exp_data,
                              input logic exp_halt, input logic exp_full, input logic [5:0] exp_count);
    checks++;
    if (deque_data !== exp_data) begin
      errors++;
      $display("[TB] FAIL %s deque_data: got %0d expected %0d", name, deque_data, exp_data);
    end
    checks++;
    if (halt !== exp_halt) begin
      errors++;
      $display("[TB] FAIL %s halt: got %0b expected %0b", name, halt, exp_halt);
    end
    checks++;
    if (full !== exp_full) begin
      errors++;
      $display("[TB] FAIL %s full: got %0b expected %0b", name, full, exp_full);
    end
    checks++;
    if (count !== exp_count) begin
      errors++;
      $display("[TB] FAIL %s count: got %0d expected %0d", name, count, exp_count);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic f, input logic e,
                                input logic [WIDTH-1:0] d, input logic q);
    @(negedge clk);
    stall      = s;
    flush      = f;
    enque      = e;
    enque_data = d;
    deque      = q;
  endtask

  function automatic vec_t mk(input logic s, input logic f, input logic e, input int d,
                              input logic q, input int xd, input logic xh, input logic xf, input int xc);
    vec_t v;
    v.stall = s; v.flush = f; v.enque = e; v.data = WIDTH'(d); v.deque = q;
    v.exp_data = WIDTH'(xd); v.exp_halt = xh; v.exp_full = xf; v.exp_count = 6'(xc);
    return v;
  endfunction

  initial begin
    //           stall flush enq data deq | data halt full count
    vecs[0]  = mk(0, 0, 0,  0, 1,   0, 1, 0, 0);
    vecs[1]  = mk(0, 0, 1,  5, 0,   0, 1, 0, 0);
    vecs[2]  = mk(0, 0, 1,  9, 0,   5, 0, 0, 1);
    vecs[3]  = mk(0, 0, 1, 17, 0,   5, 0, 0, 2);
    vecs[4]  = mk(0, 0, 0,  0, 1,   5, 0, 0, 3);
    vecs[5]  = mk(0, 0, 0,  0, 1,   9, 0, 0, 2);
    vecs[6]  = mk(0, 0, 0,  0, 1,  17, 0, 0, 1);
    vecs[7]  = mk(0, 0, 0,  0, 0,   0, 1, 0, 0);
    vecs[8]  = mk(0, 0, 1, 20, 1,   0, 1, 0, 0);
    vecs[9]  = mk(0, 0, 0,  0, 0,  20, 0, 0, 1);
    vecs[10] = mk(0, 0, 0,  0, 1,  20, 0, 0, 1);
    vecs[11] = mk(0, 0, 0,  0, 0,   0, 1, 0, 0);
    vecs[12] = mk(0, 0, 1,  7, 0,   0, 1, 0, 0);
    vecs[13] = mk(0, 0, 1,  8, 0,   7, 0, 0, 1);
    vecs[14] = mk(1, 0, 1, 12, 1,   7, 0, 0, 2);
    vecs[15] = mk(0, 0, 0,  0, 1,   7, 0, 0, 3);
    vecs[16] = mk(0, 0, 0,  0, 1,   8, 0, 0, 2);
    vecs[17] = mk(0, 0, 0,  0, 1,  12, 0, 0, 1);
    vecs[18] = mk(0, 0, 0,  0, 0,   0, 1, 0, 0);
    vecs[19] = mk(0, 0, 1,  1, 0,   0, 1, 0, 0);
    vecs[20] = mk(0, 0, 1,  2, 0,   1, 0, 0, 1);
    vecs[21] = mk(0, 0, 1,  3, 0,   1, 0, 0, 2);
    vecs[22] = mk(0, 0, 1,  4, 0,   1, 0, 0, 3);
    vecs[23] = mk(0, 1, 1, 50, 1,   1, 0, 0, 4);
    vecs[24] = mk(0, 0, 0,  0, 0,   0, 1, 0, 0);
    vecs[25] = mk(0, 0, 1, 33, 0,   0, 1, 0, 0);
    vecs[26] = mk(0, 0, 0,  0, 0,  33, 0, 0, 1);
    vecs[27] = mk(0, 1, 0,  0, 0,  33, 0, 0, 1);
    vecs[28] = mk(0, 0, 0,  0, 0,   0, 1, 0, 0);

    reset = 1'b1; stall = 0; flush = 0; enque = 0; enque_data = '0; deque = 0;
    repeat (2) @(negedge clk);
    #1 check_output("reset", 0, 1, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 29; i++) begin
      apply_stimulus(vecs[i].stall, vecs[i].flush, vecs[i].enque, vecs[i].data, vecs[i].deque);
      #1 check_output($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_halt,
                      vecs[i].exp_full, vecs[i].exp_count);
    end

    // Fill to capacity, then exercise overflow and the full simultaneous push/pop.
    for (int i = 0; i < LENGTH; i++)
      apply_stimulus(0, 0, 1, WIDTH'(i), 0);
    apply_stimulus(0, 0, 1, 6'd63, 0);
    #1 check_output("filled", 0, 0, 1, 32);
    apply_stimulus(0, 0, 1, 6'd40, 1);
    #1 check_output("overflow_ignored", 0, 0, 1, 32);
    apply_stimulus(0, 0, 0, 0, 1);
    #1 check_output("full_push_pop", 1, 0, 1, 32);
    for (int i = 1; i < LENGTH; i++) begin
      if (i > 1) apply_stimulus(0, 0, 0, 0, 1);
      #1 check_output($sformatf("drain%0d", i), WIDTH'(i), 0, (i == 1), 6'(LENGTH + 1 - i));
    end
    apply_stimulus(0, 0, 0, 0, 1);
    #1 check_output("drain_new_word", 40, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0);
    #1 check_output("drained", 0, 1, 0, 0);

    // Asynchronous reset between clock edges with ten entries held.
    for (int i = 0; i < 10; i++)
      apply_stimulus(0, 0, 1, WIDTH'(i + 10), 0);
    apply_stimulus(0, 0, 0, 0, 0);
    #1 check_output("ten_entries", 10, 0, 0, 10);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_output("async_reset", 0, 1, 0, 0);
    reset = 1'b0;
    apply_stimulus(0, 0, 1, 6'd21, 0);
    #1 check_output("after_reset", 0, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    #1 check_output("resume", 21, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
